ranging_scheduler: RTL and testbench

Sequences the two ultrasonic ranging channels (`trigger[1:0]` / `echo[1:0]`) of the range-sensor top level. It fires one sensor at a time in strict alternation, times the echo pulse and converts it to centimetres. Each result, or timeout, is handed to the downstream display/UART formatter over a valid/ready handshake. It is the only block that drives `trigger`, so the two sensors never ping simultaneously and cannot cross-talk.

---
 rtl/ranging_scheduler.sv | 167 ++++++++++++++++
 tb/tb_ranging_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ranging_scheduler.sv
// Two-channel ultrasonic ranging sequencer: fires one sensor at a time, times the
// echo pulse, converts it to centimetres and hands each result downstream.
module ranging_scheduler #(
  parameter int TRIG_CYCLES  = 500,
  parameter int CM_DIV       = 2900,
  parameter int ECHO_TIMEOUT = 1_900_000,
  parameter int GUARD_CYCLES = 3_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  echo,
  output logic [1:0]  trigger,
  output logic [15:0] dist_cm,
  output logic        dist_sensor,
  output logic        dist_timeout,
  output logic        dist_valid,
  input  logic        dist_ready,
  output logic [2:0]  fsm_state
);

  localparam int MAX_TE  = (TRIG_CYCLES > ECHO_TIMEOUT) ? TRIG_CYCLES : ECHO_TIMEOUT;
  localparam int MAX_CNT = (MAX_TE > GUARD_CYCLES) ? MAX_TE : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;
  localparam int SUB_W   = $clog2(CM_DIV) + 1;

  localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(CM_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_REPORT, S_GUARD
  } state_t;

  state_t            state;
  logic              sel;
  logic [CNT_W-1:0]  cnt;
  logic [SUB_W-1:0]  sub;
  logic [15:0]       cm;
  logic [1:0]        echo_m;
  logic [1:0]        echo_s;
  logic [1:0]        echo_d;
  logic              cur;
  logic              prev;

  assign fsm_state = state;
  assign cur       = echo_s[sel];
  assign prev      = echo_d[sel];

  // Two-flop synchronizer plus one delayed copy for rise detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_m <= 2'b00;
      echo_s <= 2'b00;
      echo_d <= 2'b00;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  // Result handshake: dist_valid rises with all dist_* fields, which then hold
  // until a cycle with dist_valid=1 and dist_ready=1; valid drops the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sel          <= 1'b0;
      cnt          <= '0;
      sub          <= '0;
      cm           <= 16'd0;
      trigger      <= 2'b00;
      dist_cm      <= 16'd0;
      dist_sensor  <= 1'b0;
      dist_timeout <= 1'b0;
      dist_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state   <= S_TRIG;
            trigger <= sel ? 2'b10 : 2'b01;
            cnt     <= '0;
          end
        end
        S_TRIG: begin
          if (cnt == TRIG_LAST) begin
            trigger <= 2'b00;
            cnt     <= '0;
            state   <= S_WAIT_RISE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_RISE: begin
          if (cur && !prev) begin
            // The rising cycle is already the first high cycle of the pulse.
            state <= S_MEASURE;
            cnt   <= CNT_W'(1);
            if (CM_DIV == 1) begin
              cm  <= 16'd1;
              sub <= '0;
            end else begin
              cm  <= 16'd0;
              sub <= SUB_W'(1);
            end
          end else if (cnt == TMO_LAST) begin
            dist_cm      <= 16'hFFFF;
            dist_timeout <= 1'b1;
            dist_sensor  <= sel;
            dist_valid   <= 1'b1;
            state        <= S_REPORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MEASURE: begin
          if (!cur) begin
            dist_cm      <= cm;
            dist_timeout <= 1'b0;
            dist_sensor  <= sel;
            dist_valid   <= 1'b1;
            state        <= S_REPORT;
          end else if (cnt == TMO_LAST) begin
            dist_cm      <= 16'hFFFF;
            dist_timeout <= 1'b1;
            dist_sensor  <= sel;
            dist_valid   <= 1'b1;
            state        <= S_REPORT;
          end else begin
            cnt <= cnt + 1'b1;
            if (sub == SUB_LAST) begin
              sub <= '0;
              if (cm != 16'hFFFE) cm <= cm + 16'd1;
            end else begin
              sub <= sub + 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (dist_ready) begin
            dist_valid <= 1'b0;
            cnt        <= '0;
            state      <= S_GUARD;
          end
        end
        S_GUARD: begin
          if (cnt == GUARD_LAST) begin
            sel <= ~sel;
            cnt <= '0;
            if (enable) begin
              state   <= S_TRIG;
              trigger <= sel ? 2'b01 : 2'b10;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ranging_scheduler.sv
// Bench for ranging_scheduler: timeline model of each measurement computed from
// edge arithmetic, per-cycle output compare and a result scoreboard queue.
module tb_ranging_scheduler;

  localparam int TRIG  = 5;
  localparam int DIV   = 10;
  localparam int TMO   = 200;
  localparam int GUARD = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  echo = 2'b00;
  logic        dist_ready = 1'b1;
  logic [1:0]  trigger;
  logic [15:0] dist_cm;
  logic        dist_sensor;
  logic        dist_timeout;
  logic        dist_valid;
  logic [2:0]  fsm_state;

  ranging_scheduler #(
    .TRIG_CYCLES(TRIG), .CM_DIV(DIV), .ECHO_TIMEOUT(TMO), .GUARD_CYCLES(GUARD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo), .trigger(trigger),
    .dist_cm(dist_cm), .dist_sensor(dist_sensor), .dist_timeout(dist_timeout),
    .dist_valid(dist_valid), .dist_ready(dist_ready), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_edge = 0;
  int model_sel = 0;

  logic [1:0]  exp_trigger = 2'b00;
  logic        exp_valid = 1'b0;
  logic [15:0] exp_cm = 16'd0;
  logic        exp_sensor = 1'b0;
  logic        exp_to = 1'b0;
  logic [17:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, want, n_edge);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n_edge++;
    #1;
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [17:0] e;
    chk("trigger", {30'd0, trigger}, {30'd0, exp_trigger});
    chk("dist_valid", {31'd0, dist_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      chk("dist_cm", {16'd0, dist_cm}, {16'd0, exp_cm});
      chk("dist_sensor", {31'd0, dist_sensor}, {31'd0, exp_sensor});
      chk("dist_timeout", {31'd0, dist_timeout}, {31'd0, exp_to});
    end
    if (dist_valid && dist_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected: got %0h expected none", {dist_timeout, dist_sensor, dist_cm});
      end else begin
        e = exp_q.pop_front();
        checks--;
        chk("result", {14'd0, dist_timeout, dist_sensor, dist_cm}, {14'd0, e});
      end
    end
  end

  // ---------------- driver: one full measurement ----------------
  // Called with the trigger due to rise after the next edge. a: raw echo rise
  // relative to trigger drop (negative = during trigger); len: raw high cycles
  // (0 = never); w: cycles of dist_ready low once valid; noise: 0 quiet,
  // 1 random, 2 mirror on the other echo line; drop_en: drop enable during
  // MEASURE and re-enable 7 cycles after the guard ends.
  task automatic meas(input int a, input int len, input int w, input int noise,
                      input bit drop_en, input int lit_cm);
    int s, t_rise, tt, r, v, h, ex, last, cmv, n;
    bit to;
    s      = model_sel;
    t_rise = n_edge + 1;
    tt     = t_rise + TRIG;
    r      = tt + a + 3;
    if (len == 0 || a < 0 || a + 3 > TMO) begin
      to = 1'b1; v = tt + TMO;
    end else if (len >= TMO) begin
      to = 1'b1; v = r + TMO - 1;
    end else begin
      to = 1'b0; v = tt + a + len + 3;
    end
    cmv  = to ? 32'hFFFF : len / DIV;
    h    = v + w + 1;
    ex   = h + GUARD;
    last = drop_en ? ex + 7 : ex - 1;
    exp_q.push_back({to, s[0], cmv[15:0]});
    while (n_edge < last) begin
      tick();
      n = n_edge;
      exp_trigger = (n < tt) ? (s == 1 ? 2'b10 : 2'b01) : 2'b00;
      if (n == v) begin
        exp_cm     = cmv[15:0];
        exp_sensor = s[0];
        exp_to     = to;
      end
      exp_valid = (n >= v && n < h);
      echo[s] = (n >= tt + a && n < tt + a + len);
      if (noise == 1)      echo[1-s] = 1'($urandom_range(0, 1));
      else if (noise == 2) echo[1-s] = echo[s];
      else                 echo[1-s] = 1'b0;
      dist_ready = !(n >= v && n < v + w);
      if (drop_en && n == r + 2) enable = 1'b0;
      if (drop_en && n == ex + 7) enable = 1'b1;
      if (n == v && lit_cm >= 0) chk("lit_cm", {16'd0, dist_cm}, lit_cm);
    end
    model_sel = 1 - s;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a, len, w, noise;
    bit drop;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_trigger", {30'd0, trigger}, 32'd0);
    chk("rst_valid", {31'd0, dist_valid}, 32'd0);
    chk("rst_cm", {16'd0, dist_cm}, 32'd0);
    chk("rst_sensor", {31'd0, dist_sensor}, 32'd0);
    chk("rst_timeout", {31'd0, dist_timeout}, 32'd0);
    chk("rst_state_idle", {29'd0, fsm_state}, 32'd0);
    repeat (3) tick();
    enable = 1'b1;

    meas(3, 47, 0, 0, 0, 4);
    meas(10, 30, 0, 2, 0, 3);
    meas(0, 0, 0, 1, 0, 65535);
    meas(-4, 250, 0, 0, 0, 65535);
    meas(20, 25, 50, 1, 0, 2);
    meas(5, 60, 0, 0, 1, 6);
    meas(0, 199, 0, 0, 0, 19);
    meas(0, 200, 0, 0, 0, 65535);
    meas(197, 15, 0, 0, 0, 1);
    meas(198, 15, 0, 0, 0, 65535);
    meas(2, 9, 0, 1, 0, 0);
    meas(2, 10, 0, 1, 0, 1);

    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, 150);
      case ($urandom_range(0, 9))
        0:       len = $urandom_range(200, 230);
        1:       len = 0;
        default: len = $urandom_range(1, 199);
      endcase
      w     = $urandom_range(0, 4);
      noise = $urandom_range(0, 2);
      drop  = ($urandom_range(0, 7) == 0) && len >= 3 && len < TMO;
      meas(a, len, w, noise, drop, -1);
    end

    // Asynchronous reset in the middle of a trigger pulse.
    tick();
    exp_trigger = (model_sel == 1) ? 2'b10 : 2'b01;
    tick();
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    echo = 2'b00;
    exp_trigger = 2'b00;
    exp_valid = 1'b0;
    model_sel = 0;
    #1;
    chk("async_rst_trigger", {30'd0, trigger}, 32'd0);
    chk("async_rst_valid", {31'd0, dist_valid}, 32'd0);
    chk("async_rst_cm", {16'd0, dist_cm}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    enable = 1'b1;
    meas(4, 33, 1, 1, 0, 3);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
